// File: rtl/fir_pkg.sv
// Package: fir_pkg
// Shared widths and result formatting for the FIR MAC datapath and the output
// formatter.
//   sat_fmt(acc, out_w, is_signed, sat) -> {clip, value}
//     acc       : accumulator already sign/zero-extended to FMT_W bits
//     out_w     : result width (1..FMT_W-1)
//     is_signed : two's-complement interpretation
//     sat       : 1 clamps to the out_w range, 0 keeps the low out_w bits
//     value     : formatted result (callers use its low out_w bits)
//     clip      : set when formatting changed the value
package fir_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_COEF_W = 16;
    localparam int unsigned DEF_ACC_W  = 39;
    localparam int unsigned DEF_OUT_W  = 32;

    localparam int unsigned FMT_W = 64;

    typedef logic [FMT_W-1:0] fmt_word_t;

    typedef struct packed {
        logic      clip;
        fmt_word_t value;
    } fmt_res_t;

    function automatic fmt_res_t sat_fmt(input fmt_word_t   acc,
                                         input int unsigned out_w,
                                         input logic        is_signed,
                                         input logic        sat);
        fmt_res_t  r;
        fmt_word_t mask;
        fmt_word_t hi;
        fmt_word_t lo;
        fmt_word_t sbit;
        fmt_word_t trunc;

        mask = (fmt_word_t'(1) << out_w) - fmt_word_t'(1);
        if (is_signed) begin
            hi = mask >> 1;   // 2^(out_w-1)-1
            lo = ~hi;         // -2^(out_w-1)
        end else begin
            hi = mask;
            lo = '0;
        end

        // Low out_w bits, re-extended so they can be compared with acc.
        sbit  = acc & (fmt_word_t'(1) << (out_w - 1));
        trunc = acc & mask;
        if (is_signed && (sbit != '0)) begin
            trunc = trunc | ~mask;
        end

        r.value = acc;
        r.clip  = 1'b0;
        if (sat) begin
            if (is_signed) begin
                if ($signed(acc) > $signed(hi)) begin
                    r.value = hi;
                    r.clip  = 1'b1;
                end else if ($signed(acc) < $signed(lo)) begin
                    r.value = lo;
                    r.clip  = 1'b1;
                end
            end else if (acc > hi) begin
                r.value = hi;
                r.clip  = 1'b1;
            end
        end else begin
            r.value = trunc;
            r.clip  = (trunc != acc);
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_mult.sv
// Module: fir_mac_mult
// Two-stage operand/product pipe of the MAC engine.
//   S1 registers the operands and frame tags, S2 registers the full-width
//   product. Both stages advance only when en is high.
// Ports:
//   clk, rstn            clock, async active-low reset
//   en                   pipe advance enable (low while the output stalls)
//   in_valid/x/c         operand pair (in_valid already qualified by the caller)
//   in_first/in_last     frame tags
//   prod_valid/prod      S2 product, DATA_W+COEF_W bits
//   prod_first/prod_last S2 frame tags
module fir_mac_mult
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned SIGNED = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_x,
    input  logic [COEF_W-1:0]        in_c,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     prod_valid,
    output logic [DATA_W+COEF_W-1:0] prod,
    output logic                     prod_first,
    output logic                     prod_last
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic        SGN    = (SIGNED != 0);

    logic [DATA_W-1:0] x_q;
    logic [COEF_W-1:0] c_q;
    logic              v1_q, f1_q, l1_q;
    logic [PROD_W-1:0] x_ext, c_ext, prod_d;
    logic [PROD_W-1:0] prod_q;
    logic              v2_q, f2_q, l2_q;

    // Extending both operands to PROD_W makes the low PROD_W bits of a plain
    // multiply correct for either signedness.
    always_comb begin
        x_ext  = {{COEF_W{SGN & x_q[DATA_W-1]}}, x_q};
        c_ext  = {{DATA_W{SGN & c_q[COEF_W-1]}}, c_q};
        prod_d = x_ext * c_ext;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q    <= '0;
            c_q    <= '0;
            v1_q   <= 1'b0;
            f1_q   <= 1'b0;
            l1_q   <= 1'b0;
            prod_q <= '0;
            v2_q   <= 1'b0;
            f2_q   <= 1'b0;
            l2_q   <= 1'b0;
        end else if (en) begin
            x_q    <= in_x;
            c_q    <= in_c;
            v1_q   <= in_valid;
            f1_q   <= in_first;
            l1_q   <= in_last;
            prod_q <= prod_d;
            v2_q   <= v1_q;
            f2_q   <= f1_q;
            l2_q   <= l1_q;
        end
    end

    assign prod_valid = v2_q;
    assign prod       = prod_q;
    assign prod_first = f2_q;
    assign prod_last  = l2_q;

endmodule

// File: rtl/fir_mac_pipe.sv
// Module: fir_mac_pipe
// Pipelined multiply-accumulate engine: consumes (sample, coefficient) pairs
// framed by first/last tags and emits one formatted dot product per frame.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   in_valid/in_ready         input pair handshake
//   in_x, in_c                sample and coefficient
//   in_first, in_last         frame start (clears acc) / frame end (emits result)
//   out_valid/out_ready       result handshake; out_* held while stalled
//   out_result, out_ovf       formatted dot product and overflow/clip flag
// Pipe: S1/S2 in fir_mac_mult, S3 accumulate, then a result register that
// formats the frame total, then the output register (last pair -> out at T+3).
module fir_mac_pipe
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned COEF_W   = DEF_COEF_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned OUT_W    = DEF_OUT_W,
    parameter int unsigned SIGNED   = 1,
    parameter int unsigned SATURATE = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [COEF_W-1:0] in_c,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_result,
    output logic              out_ovf
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic        SGN    = (SIGNED != 0);
    localparam logic        SAT    = (SATURATE != 0);

    logic              stall;
    logic              s2_valid, s2_first, s2_last;
    logic [PROD_W-1:0] s2_prod;

    logic [ACC_W-1:0]  acc_q;
    logic              sticky_q;
    logic              res_valid_q;
    logic [ACC_W-1:0]  res_acc_q;
    logic              res_ovf_q;
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_result_q;
    logic              out_ovf_q;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    sum;
    logic              add_ovf;
    logic [ACC_W-1:0]  acc_n;
    logic              frame_ovf;
    fmt_word_t         fmt_in;
    fmt_res_t          fmt;
    logic              unused_fmt_hi;

    // Everything holds while a result waits downstream, so nothing is lost.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    fir_mac_mult #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk        (clk),
        .rstn       (rstn),
        .en         (~stall),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_c       (in_c),
        .in_first   (in_first),
        .in_last    (in_last),
        .prod_valid (s2_valid),
        .prod       (s2_prod),
        .prod_first (s2_first),
        .prod_last  (s2_last)
    );

    // S3 accumulate
    always_comb begin
        prod_ext = ACC_W'(s2_prod);
        if (SGN && s2_prod[PROD_W-1]) begin
            prod_ext = prod_ext | ~(ACC_W'({PROD_W{1'b1}}));
        end
        sum = {1'b0, acc_q} + {1'b0, prod_ext};
        if (SGN) begin
            add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            add_ovf = sum[ACC_W];
        end
        if (s2_first) begin
            acc_n     = prod_ext;
            frame_ovf = 1'b0;   // a single product always fits ACC_W
        end else begin
            acc_n     = sum[ACC_W-1:0];
            frame_ovf = sticky_q | add_ovf;
        end
    end

    // Format the registered frame total
    always_comb begin
        fmt_in = fmt_word_t'(res_acc_q);
        if (SGN && res_acc_q[ACC_W-1]) begin
            fmt_in = fmt_in | ~(fmt_word_t'({ACC_W{1'b1}}));
        end
        fmt = sat_fmt(fmt_in, OUT_W, SGN, SAT);
    end

    assign unused_fmt_hi = ^fmt.value[FMT_W-1:OUT_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q        <= '0;
            sticky_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_acc_q    <= '0;
            res_ovf_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
        end else if (!stall) begin
            if (s2_valid) begin
                // Clearing on last lets a frame without a first tag start at 0.
                if (s2_last) begin
                    acc_q    <= '0;
                    sticky_q <= 1'b0;
                end else begin
                    acc_q    <= acc_n;
                    sticky_q <= frame_ovf;
                end
            end
            res_valid_q <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                res_acc_q <= acc_n;
                res_ovf_q <= frame_ovf;
            end
            // Not stalled: the output register is empty or draining this edge.
            out_valid_q <= res_valid_q;
            if (res_valid_q) begin
                out_result_q <= fmt.value[OUT_W-1:0];
                out_ovf_q    <= res_ovf_q | fmt.clip;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_fir_mac_pipe.sv
// Bench for fir_mac_pipe. Three instances share one input stream and out_ready:
//   dut0 default (signed, OUT_W=32), dut1 signed OUT_W=16, dut2 unsigned OUT_W=32.
// Expected results come from an exact-arithmetic model pushed into per-instance
// queues on acceptance and popped by a monitor as results transfer.
module tb_fir_mac_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_x = '0;
    logic [15:0] in_c = '0;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic [31:0] res0, res2;
    logic [15:0] res1;

    always #5 clk = ~clk;

    fir_mac_pipe u_dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir0), .in_x(in_x),
        .in_c(in_c), .in_first(in_first), .in_last(in_last), .out_valid(ov0),
        .out_ready(out_ready), .out_result(res0), .out_ovf(of0)
    );

    fir_mac_pipe #(.OUT_W(16)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir1), .in_x(in_x),
        .in_c(in_c), .in_first(in_first), .in_last(in_last), .out_valid(ov1),
        .out_ready(out_ready), .out_result(res1), .out_ovf(of1)
    );

    fir_mac_pipe #(.SIGNED(0)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir2), .in_x(in_x),
        .in_c(in_c), .in_first(in_first), .in_last(in_last), .out_valid(ov2),
        .out_ready(out_ready), .out_result(res2), .out_ovf(of2)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t        sbq [3][$];
    longint      run_sum [3];
    logic [31:0] last_res [3];
    logic        last_ovf [3];
    int          ndone [3];
    logic [31:0] log0 [$];
    int          total = 0;
    int          bad = 0;

    logic [31:0] act_res [3];
    logic        act_v [3];
    logic        act_o [3];

    assign act_res[0] = res0;
    assign act_res[1] = {16'b0, res1};
    assign act_res[2] = res2;
    assign act_v[0]   = ov0;
    assign act_v[1]   = ov1;
    assign act_v[2]   = ov2;
    assign act_o[0]   = of0;
    assign act_o[1]   = of1;
    assign act_o[2]   = of2;

    // Exact sum -> wrap to a 39-bit accumulator -> clamp to ow bits.
    function automatic exp_t model_fmt(input longint s, input bit sg, input int ow);
        exp_t   r;
        longint w, hi, lo, v;
        bit     clip;
        w = s & ((longint'(1) << 39) - 1);
        if (sg && w[38]) w = w - (longint'(1) << 39);
        if (sg) begin
            hi = (longint'(1) << (ow - 1)) - 1;
            lo = -(longint'(1) << (ow - 1));
        end else begin
            hi = (longint'(1) << ow) - 1;
            lo = 0;
        end
        v    = w;
        clip = 1'b0;
        if (w > hi) begin
            v    = hi;
            clip = 1'b1;
        end else if (w < lo) begin
            v    = lo;
            clip = 1'b1;
        end
        r.res = 32'(v & ((longint'(1) << ow) - 1));
        r.ovf = (w != s) | clip;
        return r;
    endfunction

    // Scoreboard monitor: a result transfers at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && out_ready) begin
            for (int k = 0; k < 3; k++) begin
                if (act_v[k]) begin
                    total++;
                    if (sbq[k].size() == 0) begin
                        bad++;
                        $display("FAIL sb%0d extra result got=%h ovf=%b expected none",
                                 k, act_res[k], act_o[k]);
                    end else begin
                        e = sbq[k].pop_front();
                        if (act_res[k] !== e.res || act_o[k] !== e.ovf) begin
                            bad++;
                            $display("FAIL sb%0d result got=%h ovf=%b expected=%h ovf=%b",
                                     k, act_res[k], act_o[k], e.res, e.ovf);
                        end
                    end
                    last_res[k] = act_res[k];
                    last_ovf[k] = act_o[k];
                    ndone[k]++;
                    if (k == 0) log0.push_back(act_res[k]);
                end
            end
        end
    end

    task automatic send_pair(input logic [15:0] x, input logic [15:0] c,
                             input logic f, input logic l);
        bit ok;
        in_x     = x;
        in_c     = c;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = ir0;
            @(posedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout in_ready=%b expected=1", ir0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                longint xs, cs;
                if (k == 2) begin
                    xs = longint'({48'b0, x});
                    cs = longint'({48'b0, c});
                end else begin
                    xs = longint'($signed(x));
                    cs = longint'($signed(c));
                end
                if (f) run_sum[k] = 0;
                run_sum[k] += xs * cs;
                if (l) begin
                    sbq[k].push_back(model_fmt(run_sum[k], k != 2, (k == 1) ? 16 : 32));
                    run_sum[k] = 0;
                end
            end
        end
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        int pending;
        pending = sbq[0].size() + sbq[1].size() + sbq[2].size();
        while (pending != 0 && n < 60) begin
            @(posedge clk);
            n++;
            pending = sbq[0].size() + sbq[1].size() + sbq[2].size();
        end
        total++;
        if (pending != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", pending);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle out_valid=%b in_ready=%b expected 0/1", ov0, ir0);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        // Partial frame, then reset while it sits in the accumulator.
        send_pair(16'd7, 16'd9, 1'b1, 1'b0);
        send_pair(16'd1, 16'd1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        total++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || u_dut0.acc_q !== '0) begin
            bad++;
            $display("FAIL reset_midframe out_valid=%b in_ready=%b acc=%h expected 0/1/0",
                     ov0, ir0, u_dut0.acc_q);
        end
        for (int k = 0; k < 3; k++) run_sum[k] = 0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        // One-pair frame: out_valid must rise exactly after edge T+3.
        send_pair(16'd3, 16'd4, 1'b1, 1'b1);
        for (int d = 1; d <= 3; d++) begin
            @(posedge clk);
            #1;
            total++;
            if (ov0 !== (d == 3)) begin
                bad++;
                $display("FAIL latency T+%0d out_valid=%b expected=%b", d, ov0, (d == 3));
            end
        end
        total++;
        if (res0 !== 32'd12) begin
            bad++;
            $display("FAIL latency_result got=%0d expected=12", res0);
        end
        wait_idle();
    endtask

    task automatic test_signed_frame();
        send_pair(16'd1,     16'd5,     1'b1, 1'b0);
        send_pair(16'hFFFE,  16'd6,     1'b0, 1'b0);
        send_pair(16'd3,     16'hFFF9,  1'b0, 1'b0);
        send_pair(16'hFFFC,  16'd8,     1'b0, 1'b1);
        wait_idle();
        total++;
        if (last_res[0] !== 32'hFFFF_FFC4 || last_ovf[0] !== 1'b0) begin
            bad++;
            $display("FAIL signed4 got=%h ovf=%b expected=ffffffc4 ovf=0",
                     last_res[0], last_ovf[0]);
        end
        total++;
        if (last_res[1] !== 32'h0000_FFC4) begin
            bad++;
            $display("FAIL signed4_w16 got=%h expected=0000ffc4", last_res[1]);
        end
    endtask

    task automatic test_back_to_back();
        int  n0;
        bit  dropped;
        n0      = ndone[0];
        dropped = 1'b0;
        fork
            begin
                send_pair(16'd1, 16'd1, 1'b1, 1'b1);
                send_pair(16'd2, 16'd3, 1'b1, 1'b0);
                send_pair(16'd4, 16'd5, 1'b0, 1'b0);
                send_pair(16'd6, 16'd7, 1'b0, 1'b1);
            end
            begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!ir0) dropped = 1'b1;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        total++;
        if (dropped !== 1'b1) begin
            bad++;
            $display("FAIL bp_in_ready_drop seen=%b expected=1", dropped);
        end
        total++;
        if (ndone[0] - n0 != 2) begin
            bad++;
            $display("FAIL bp_count got=%0d expected=2", ndone[0] - n0);
        end
        total++;
        if (log0[log0.size()-2] !== 32'd1 || log0[log0.size()-1] !== 32'd68) begin
            bad++;
            $display("FAIL bp_order got=%0d,%0d expected=1,68",
                     log0[log0.size()-2], log0[log0.size()-1]);
        end
    endtask

    task automatic test_saturation();
        send_pair(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        send_pair(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
        wait_idle();
        total++;
        if (last_res[1] !== 32'h0000_7FFF || last_ovf[1] !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos got=%h ovf=%b expected=00007fff ovf=1",
                     last_res[1], last_ovf[1]);
        end
        total++;
        if (last_res[0] !== 32'h7FFE_0002 || last_ovf[0] !== 1'b0) begin
            bad++;
            $display("FAIL sat_pos_w32 got=%h ovf=%b expected=7ffe0002 ovf=0",
                     last_res[0], last_ovf[0]);
        end
        send_pair(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        send_pair(16'h8000, 16'h7FFF, 1'b0, 1'b1);
        wait_idle();
        total++;
        if (last_res[1] !== 32'h0000_8000 || last_ovf[1] !== 1'b1) begin
            bad++;
            $display("FAIL sat_neg got=%h ovf=%b expected=00008000 ovf=1",
                     last_res[1], last_ovf[1]);
        end
        total++;
        if (last_res[0] !== 32'h8001_0000) begin
            bad++;
            $display("FAIL sat_neg_w32 got=%h expected=80010000", last_res[0]);
        end
    endtask

    task automatic test_no_first();
        send_pair(16'd2, 16'd2, 1'b1, 1'b1);
        send_pair(16'd3, 16'd3, 1'b0, 1'b1);
        wait_idle();
        total++;
        if (log0[log0.size()-2] !== 32'd4 || log0[log0.size()-1] !== 32'd9) begin
            bad++;
            $display("FAIL no_first got=%0d,%0d expected=4,9",
                     log0[log0.size()-2], log0[log0.size()-1]);
        end
    endtask

    task automatic test_unsigned();
        send_pair(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_idle();
        total++;
        if (last_res[2] !== 32'hFFFE_0001 || last_ovf[2] !== 1'b0) begin
            bad++;
            $display("FAIL unsigned got=%h ovf=%b expected=fffe0001 ovf=0",
                     last_res[2], last_ovf[2]);
        end
        total++;
        if (last_res[0] !== 32'd1) begin
            bad++;
            $display("FAIL unsigned_as_signed got=%h expected=00000001", last_res[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            run_sum[k]  = 0;
            ndone[k]    = 0;
            last_res[k] = '0;
            last_ovf[k] = 1'b0;
        end
        #1;
        test_reset();
        test_signed_frame();
        test_back_to_back();
        test_saturation();
        test_no_first();
        test_unsigned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
